// File: rtl/calc_pkg.sv
// Shared key/character definitions for the keypad front end and the calculator FSM.
// Also carries the scanner state type and the key-vector helpers.
package calc_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_1     = 8'h31;
  localparam logic [7:0] CH_2     = 8'h32;
  localparam logic [7:0] CH_3     = 8'h33;
  localparam logic [7:0] CH_4     = 8'h34;
  localparam logic [7:0] CH_5     = 8'h35;
  localparam logic [7:0] CH_6     = 8'h36;
  localparam logic [7:0] CH_7     = 8'h37;
  localparam logic [7:0] CH_8     = 8'h38;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_CLR   = 8'h43;

  localparam logic [3:0] KEY_SPARE = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EMIT     = 2'd1,
    S_WAIT_REL = 2'd2
  } kp_state_t;

  // Key index is row*4 + col; the spare position maps to NUL.
  function automatic logic [7:0] keymap(input logic [3:0] idx);
    case (idx)
      4'd0:    keymap = CH_1;
      4'd1:    keymap = CH_2;
      4'd2:    keymap = CH_3;
      4'd3:    keymap = CH_PLUS;
      4'd4:    keymap = CH_4;
      4'd5:    keymap = CH_5;
      4'd6:    keymap = CH_6;
      4'd7:    keymap = CH_MINUS;
      4'd8:    keymap = CH_7;
      4'd9:    keymap = CH_8;
      4'd10:   keymap = CH_9;
      4'd11:   keymap = CH_MUL;
      4'd12:   keymap = CH_CLR;
      4'd13:   keymap = CH_0;
      4'd14:   keymap = CH_EQ;
      default: keymap = 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] key_index(input logic [15:0] v);
    key_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      key_index = v[i] ? 4'(i) : key_index;
    end
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a key vector becomes stable only after DEBOUNCE_CNT
// consecutive identical full-scan frames.
module keypad_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_done,
  input  logic [15:0] i_frame,
  output logic [15:0] o_stable
);

  localparam int MW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_CNT);

  logic [15:0]   r_prev;
  logic [15:0]   r_stable;
  logic [MW-1:0] r_match;
  logic [MW-1:0] w_match_nxt;

  // Any difference from the previous frame restarts the run; the run saturates.
  always_comb begin
    if (i_frame != r_prev) begin
      w_match_nxt = MW'(1);
    end else if (r_match >= MATCH_MAX) begin
      w_match_nxt = MATCH_MAX;
    end else begin
      w_match_nxt = r_match + MW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev   <= 16'h0000;
      r_match  <= MW'(0);
      r_stable <= 16'h0000;
    end else if (i_frame_done) begin
      r_prev  <= i_frame;
      r_match <= w_match_nxt;
      if (w_match_nxt == MATCH_MAX) begin
        r_stable <= i_frame;
      end else begin
        r_stable <= r_stable;
      end
    end else begin
      r_stable <= r_stable;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row drive, column synchroniser, frame assembly,
// debounce and a press FSM emitting one btn_valid/btn_char per accepted key.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic       btn_valid,
  output logic [7:0] btn_char,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    r_col_s1;
  logic [3:0]    r_col_s2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row;
  logic [3:0]    r_key_row;
  logic [15:0]   r_raw;
  logic          r_btn_valid;
  logic [7:0]    r_btn_char;
  logic          r_key_held;
  kp_state_t     r_state;
  kp_state_t     w_state_nxt;
  logic          w_dwell_end;
  logic          w_frame_done;
  logic [15:0]   w_frame;
  logic [15:0]   w_stable;
  logic          w_one_key;
  logic [3:0]    w_idx;
  logic          w_emit;
  logic [7:0]    w_char;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= key_col;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_dwell_end  = (r_dwell == DWELL_LAST);
  assign w_frame_done = w_dwell_end && (r_row == 2'd3);

  // Sample on the last dwell cycle so the sync chain has settled on the current row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell   <= DW'(0);
      r_row     <= 2'd0;
      r_key_row <= 4'b1110;
      r_raw     <= 16'h0000;
    end else if (w_dwell_end) begin
      r_dwell                    <= DW'(0);
      r_row                      <= r_row + 2'd1;
      r_key_row                  <= {r_key_row[2:0], r_key_row[3]};
      r_raw[{r_row, 2'b00} +: 4] <= ~r_col_s2;
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // The row-3 nibble is still in flight on the frame_done cycle.
  always_comb begin
    w_frame        = r_raw;
    w_frame[15:12] = ~r_col_s2;
  end

  keypad_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .i_frame_done(w_frame_done),
    .i_frame     (w_frame),
    .o_stable    (w_stable)
  );

  assign w_one_key = (w_stable != 16'h0000) && ((w_stable & (w_stable - 16'h0001)) == 16'h0000);
  assign w_idx     = key_index(w_stable);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_stable == 16'h0000) begin
          w_state_nxt = S_IDLE;
        end else if (w_one_key && (w_idx != KEY_SPARE)) begin
          w_state_nxt = S_EMIT;
        end else begin
          w_state_nxt = S_WAIT_REL;
        end
      end
      S_EMIT: w_state_nxt = S_WAIT_REL;
      S_WAIT_REL: begin
        if (w_stable == 16'h0000) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_REL;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_emit = (r_state == S_EMIT);
    w_char = keymap(w_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_valid <= 1'b0;
      r_btn_char  <= 8'h00;
      r_key_held  <= 1'b0;
    end else begin
      r_btn_valid <= w_emit;
      r_key_held  <= |w_stable;
      if (w_emit) begin
        r_btn_char <= w_char;
      end else begin
        r_btn_char <= r_btn_char;
      end
    end
  end

  assign key_row   = r_key_row;
  assign btn_valid = r_btn_valid;
  assign btn_char  = r_btn_char;
  assign key_held  = r_key_held;

endmodule
